traffic_phase_scheduler: RTL and testbench

//  Demand-driven phase sequencer for a main/side road junction with a pedestrian crossing.

---
 rtl/traffic_pkg.sv | 7 +
 rtl/phase_timer.sv | 12 +
 rtl/traffic_phase_scheduler.sv | 66 ++++++
 tb/tb_traffic_phase_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes and lamp encodings shared by the junction scheduler
package traffic_pkg;
  typedef enum logic [2:0] {MAIN_G, MAIN_Y, ALLRED_S, SIDE_G, SIDE_Y, ALLRED_M} phase_t;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase counter (clk, rst, clr in; cnt out), clears on clr
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: main/side junction phase FSM with ped latch and preemption (req/emerg in; lamps, walk, ped_pending, phase out)
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 7,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);
  localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RED_L  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_L = CNT_W'(WALK_T);
  phase_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             walk_en, entering;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_n != state),
    .cnt(cnt)
  );
  always_comb begin
    state_n = ALLRED_M;
    case (state)
      MAIN_G:   state_n = (emerg_req ? emerg_dir : (cnt >= MIN_L && (side_req || ped_pending))) ? MAIN_Y : MAIN_G;
      MAIN_Y:   state_n = cnt >= YEL_L ? ALLRED_S : MAIN_Y;
      ALLRED_S: state_n = cnt >= RED_L ? SIDE_G : ALLRED_S;
      SIDE_G:   state_n = (emerg_req ? !emerg_dir : ((cnt >= MIN_L && !side_req) || cnt >= MAX_L)) ? SIDE_Y : SIDE_G;
      SIDE_Y:   state_n = cnt >= YEL_L ? ALLRED_M : SIDE_Y;
      ALLRED_M: state_n = cnt >= RED_L ? MAIN_G : ALLRED_M;
      default:  state_n = ALLRED_M;
    endcase
  end
  assign entering = (state_n == SIDE_G) && (state != SIDE_G);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALLRED_M;
      ped_pending <= 1'b0;
      walk_en     <= 1'b0;
    end else begin
      state       <= state_n;
      ped_pending <= entering ? 1'b0 : (ped_pending | (ped_req & ~walk));
      walk_en     <= entering ? ped_pending : walk_en;
    end
  end
  assign light_main = state == MAIN_G ? LAMP_GRN : state == MAIN_Y ? LAMP_YEL : LAMP_RED;
  assign light_side = state == SIDE_G ? LAMP_GRN : state == SIDE_Y ? LAMP_YEL : LAMP_RED;
  assign walk       = (state == SIDE_G) && walk_en && (cnt < WALK_L);
  assign phase      = state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed checks of phase timing, ped walk, preemption and lamp safety
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;
  logic clk = 1'b0, rst = 1'b1, side_req = 1'b0, ped_req = 1'b0, emerg_req = 1'b0, emerg_dir = 1'b0;
  logic [2:0] light_main, light_side, phase;
  logic walk, ped_pending;
  int checks = 0, errors = 0;
  traffic_phase_scheduler dut (
    .clk(clk),
    .rst(rst),
    .side_req(side_req),
    .ped_req(ped_req),
    .emerg_req(emerg_req),
    .emerg_dir(emerg_dir),
    .light_main(light_main),
    .light_side(light_side),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; side_req = 1'b0; ped_req = 1'b0; emerg_req = 1'b0; emerg_dir = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask
  task automatic run_phase(input string tag, input phase_t p, input logic [2:0] m, input logic [2:0] s, input int d);
    int n = 0;
    chk({tag, "_phase"}, phase, p);
    chk({tag, "_main"}, light_main, m);
    chk({tag, "_side"}, light_side, s);
    while (phase == p && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_dur"}, n, d);
  endtask
  task automatic wait_phase(input string tag, input phase_t p);
    int n = 0;
    while (phase != p && n < 200) begin
      tick();
      n++;
    end
    chk(tag, phase, p);
  endtask
  always @(negedge clk) begin
    chk("both_nonred", light_main != LAMP_RED && light_side != LAMP_RED, 0);
    chk("walk_not_side_green", walk && light_side != LAMP_GRN, 0);
  end
  initial begin
    int n, w, ch;
    logic p_after;
    tick(); tick();
    chk("rst_main", light_main, LAMP_RED);
    chk("rst_side", light_side, LAMP_RED);
    chk("rst_walk", walk, 0);
    chk("rst_pend", ped_pending, 0);
    chk("rst_phase", phase, ALLRED_M);
    rst = 1'b0;
    tick();
    chk("rel1_phase", phase, ALLRED_M);
    tick();
    chk("rel2_phase", phase, MAIN_G);
    ch = 0;
    repeat (100) begin
      tick();
      if (phase != MAIN_G) ch++;
    end
    chk("idle_moves", ch, 0);
    chk("idle_main", light_main, LAMP_GRN);
    chk("idle_side", light_side, LAMP_RED);
    do_reset();
    side_req = 1'b1;
    run_phase("t3_mg", MAIN_G, LAMP_GRN, LAMP_RED, 10);
    run_phase("t3_my", MAIN_Y, LAMP_YEL, LAMP_RED, 3);
    run_phase("t3_ars", ALLRED_S, LAMP_RED, LAMP_RED, 2);
    run_phase("t3_sg", SIDE_G, LAMP_RED, LAMP_GRN, 30);
    run_phase("t3_sy", SIDE_Y, LAMP_RED, LAMP_YEL, 3);
    run_phase("t3_arm", ALLRED_M, LAMP_RED, LAMP_RED, 2);
    chk("t3_back", phase, MAIN_G);
    do_reset();
    repeat (4) tick();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    chk("t4_pend_set", ped_pending, 1);
    run_phase("t4_mg", MAIN_G, LAMP_GRN, LAMP_RED, 5);
    run_phase("t4_my", MAIN_Y, LAMP_YEL, LAMP_RED, 3);
    chk("t4_pend_held", ped_pending, 1);
    run_phase("t4_ars", ALLRED_S, LAMP_RED, LAMP_RED, 2);
    chk("t4_sg_phase", phase, SIDE_G);
    chk("t4_pend_clr", ped_pending, 0);
    chk("t4_walk_on", walk, 1);
    n = 0; w = 0; p_after = 1'bx;
    while (phase == SIDE_G && n < 200) begin
      w += int'(walk);
      ped_req = (n == 2 || n == 8);
      tick();
      ped_req = 1'b0;
      if (n == 2) p_after = ped_pending;
      n++;
    end
    chk("t4_sg_dur", n, 10);
    chk("t4_walk_cycles", w, 7);
    chk("t4_press_in_walk", p_after, 0);
    chk("t4_press_after_walk", ped_pending, 1);
    run_phase("t4_sy", SIDE_Y, LAMP_RED, LAMP_YEL, 3);
    run_phase("t4_arm", ALLRED_M, LAMP_RED, LAMP_RED, 2);
    run_phase("t4_mg2", MAIN_G, LAMP_GRN, LAMP_RED, 10);
    do_reset();
    tick(); tick();
    emerg_req = 1'b1; emerg_dir = 1'b1;
    tick();
    chk("t5_trunc", phase, MAIN_Y);
    run_phase("t5_my", MAIN_Y, LAMP_YEL, LAMP_RED, 3);
    run_phase("t5_ars", ALLRED_S, LAMP_RED, LAMP_RED, 2);
    ch = 0;
    repeat (50) begin
      if (phase != SIDE_G) ch++;
      tick();
    end
    chk("t5_hold_moves", ch, 0);
    chk("t5_hold_phase", phase, SIDE_G);
    emerg_req = 1'b0;
    tick();
    chk("t5_release", phase, SIDE_Y);
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    wait_phase("t5b_reach_sg", SIDE_G);
    tick(); tick();
    chk("t5b_walk_pre", walk, 1);
    emerg_req = 1'b1; emerg_dir = 1'b0;
    tick();
    chk("t5b_trunc", phase, SIDE_Y);
    chk("t5b_walk_drop", walk, 0);
    run_phase("t5b_sy", SIDE_Y, LAMP_RED, LAMP_YEL, 3);
    run_phase("t5b_arm", ALLRED_M, LAMP_RED, LAMP_RED, 2);
    side_req = 1'b1;
    ch = 0;
    repeat (40) begin
      if (phase != MAIN_G) ch++;
      tick();
    end
    chk("t5b_hold_moves", ch, 0);
    emerg_req = 1'b0;
    tick();
    chk("t5b_release", phase, MAIN_Y);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_phase", phase, ALLRED_M);
    chk("midrst_main", light_main, LAMP_RED);
    chk("midrst_side", light_side, LAMP_RED);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
